// File: rtl/serial_matmul_cmd_queue.sv
// Command FIFO between the RoCC command port and the serial_matmul engine.
// Latency: 1 cycle from enqueue to deq_val_o; with SM_CMDQ_BYPASS_EN an empty queue forwards in the same cycle.
// Backpressure: cmd_rdy_o drops when full (no same-cycle pop credit); flush_i overrides enq/deq. Optional macro: SM_CMDQ_BYPASS_EN.
module serial_matmul_cmd_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              cmd_val_i,
  output logic              cmd_rdy_o,
  input  logic [63:0]       cmd_rs1_i,
  input  logic [6:0]        cmd_funct_i,
  input  logic [6:0]        cmd_opcode_i,
  input  logic [4:0]        cmd_rd_i,
  output logic              deq_val_o,
  input  logic              deq_rdy_i,
  output logic [63:0]       deq_rs1_o,
  output logic [6:0]        deq_funct_o,
  output logic [6:0]        deq_opcode_o,
  output logic [4:0]        deq_rd_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic [63:0] rs1;
    logic [6:0]  funct;
    logic [6:0]  opcode;
    logic [4:0]  rd;
  } cmd_entry_t;

  cmd_entry_t            mem_q [DEPTH];
  logic [ADDR_W-1:0]     head_q, head_d;
  logic [ADDR_W-1:0]     tail_q, tail_d;
  logic [ADDR_W:0]       count_q, count_d;

  cmd_entry_t            cmd_entry;
  cmd_entry_t            deq_entry;
  logic                  not_empty;
  logic                  byp;
  logic                  enq;
  logic                  deq;

  assign cmd_entry = '{rs1: cmd_rs1_i, funct: cmd_funct_i, opcode: cmd_opcode_i, rd: cmd_rd_i};
  assign not_empty = (count_q != '0);

`ifdef SM_CMDQ_BYPASS_EN
  // An empty queue with a ready consumer hands the command straight through.
  assign byp = reset & ~not_empty & cmd_val_i & deq_rdy_i & ~flush_i;
`else
  assign byp = 1'b0;
`endif

  // Full refuses even when the head pops this cycle; held in reset looks neither ready nor valid.
  assign cmd_rdy_o = reset & (count_q != FULL_CNT);
  assign deq_val_o = reset & (not_empty | byp);

  // Bypassed commands are consumed without touching storage or pointers.
  assign enq = cmd_val_i & cmd_rdy_o & ~byp;
  assign deq = reset & not_empty & deq_rdy_i;

  // Head data is forced to zero whenever nothing valid is presented.
  always_comb begin
    deq_entry = '0;
    if (byp) begin
      deq_entry = cmd_entry;
    end else if (reset && not_empty) begin
      deq_entry = mem_q[head_q];
    end
  end

  assign deq_rs1_o    = deq_entry.rs1;
  assign deq_funct_o  = deq_entry.funct;
  assign deq_opcode_o = deq_entry.opcode;
  assign deq_rd_o     = deq_entry.rd;
  assign count_o      = count_q;

  // Pointer and occupancy next-state; flush discards everything including this cycle's command.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is left unreset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (enq && !flush_i) begin
      mem_q[tail_q] <= cmd_entry;
    end
  end

endmodule

// File: tb/tb_serial_matmul_cmd_queue.sv
module tb_serial_matmul_cmd_queue;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush_i;
  logic              cmd_val_i;
  logic              cmd_rdy_o;
  logic [63:0]       cmd_rs1_i;
  logic [6:0]        cmd_funct_i;
  logic [6:0]        cmd_opcode_i;
  logic [4:0]        cmd_rd_i;
  logic              deq_val_o;
  logic              deq_rdy_i;
  logic [63:0]       deq_rs1_o;
  logic [6:0]        deq_funct_o;
  logic [6:0]        deq_opcode_o;
  logic [4:0]        deq_rd_o;
  logic [ADDR_W:0]   count_o;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue contents as a list of {rs1,funct,opcode,rd} words.
  logic [82:0] mq [$];

  serial_matmul_cmd_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush_i      (flush_i),
    .cmd_val_i    (cmd_val_i),
    .cmd_rdy_o    (cmd_rdy_o),
    .cmd_rs1_i    (cmd_rs1_i),
    .cmd_funct_i  (cmd_funct_i),
    .cmd_opcode_i (cmd_opcode_i),
    .cmd_rd_i     (cmd_rd_i),
    .deq_val_o    (deq_val_o),
    .deq_rdy_i    (deq_rdy_i),
    .deq_rs1_o    (deq_rs1_o),
    .deq_funct_o  (deq_funct_o),
    .deq_opcode_o (deq_opcode_o),
    .deq_rd_o     (deq_rd_o),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [82:0] got, input logic [82:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Check every output against the model for an empty/idle input set (used around reset).
  task automatic chk_idle(input string tag, input logic exp_rdy);
    chk({tag, "_rdy"}, 83'(cmd_rdy_o), 83'(exp_rdy));
    chk({tag, "_val"}, 83'(deq_val_o), 83'(0));
    chk({tag, "_cnt"}, 83'(count_o), 83'(0));
    chk({tag, "_dat"}, {deq_rs1_o, deq_funct_o, deq_opcode_o, deq_rd_o}, 83'(0));
  endtask

  // One clock cycle: apply inputs just after an edge, check outputs before the next, update the model.
  task automatic step(input logic v, input logic [63:0] r, input logic [6:0] f, input logic [6:0] o,
                      input logic [4:0] d, input logic dr, input logic fl);
    logic        byp;
    logic        exp_rdy;
    logic        exp_val;
    logic [82:0] exp_dat;
    logic [82:0] cmd;
    cmd_val_i = v; cmd_rs1_i = r; cmd_funct_i = f; cmd_opcode_i = o; cmd_rd_i = d;
    deq_rdy_i = dr; flush_i = fl;
    cmd = {r, f, o, d};
`ifdef SM_CMDQ_BYPASS_EN
    byp = (mq.size() == 0) && v && dr && !fl;
`else
    byp = 1'b0;
`endif
    exp_rdy = (mq.size() != DEPTH);
    exp_val = (mq.size() != 0) || byp;
    exp_dat = byp ? cmd : ((mq.size() != 0) ? mq[0] : 83'(0));
    #3;
    chk("rdy", 83'(cmd_rdy_o), 83'(exp_rdy));
    chk("val", 83'(deq_val_o), 83'(exp_val));
    chk("cnt", 83'(count_o), 83'(mq.size()));
    chk("dat", {deq_rs1_o, deq_funct_o, deq_opcode_o, deq_rd_o}, exp_dat);
    if (fl) begin
      mq.delete();
    end else if (!byp) begin
      if (exp_val && dr) void'(mq.pop_front());
      if (v && exp_rdy) mq.push_back(cmd);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enq_simple(input logic [63:0] r, input logic dr);
    step(1'b1, r, 7'h05, 7'h0B, 5'd3, dr, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush_i = 1'b0; cmd_val_i = 1'b0; deq_rdy_i = 1'b0;
    cmd_rs1_i = '0; cmd_funct_i = '0; cmd_opcode_i = '0; cmd_rd_i = '0;
    repeat (2) @(posedge clk);
    #1;
    cmd_val_i = 1'b1; deq_rdy_i = 1'b1; cmd_rs1_i = 64'hDEAD;
    #1;
    chk_idle("in_reset", 1'b0);
    cmd_val_i = 1'b0; deq_rdy_i = 1'b0;
    #1 reset = 1'b1;
    @(posedge clk); #1;

    // First enqueue with consumer stalled; visible one cycle later.
    step(1'b1, 64'h1234, 7'h05, 7'h0B, 5'd3, 1'b0, 1'b0);
    step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b0, 1'b0);
    step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b0, 1'b1);

    // Fill past capacity: 5th held by source while full.
    for (int i = 1; i <= 5; i++) enq_simple(64'(i), 1'b0);
    // Full with pop request: pops but refuses the enqueue, then enqueues next cycle.
    enq_simple(64'd5, 1'b1);
    enq_simple(64'd5, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b1, 1'b0);

    // Steady enq+deq across pointer wrap with one entry pre-loaded.
    enq_simple(64'd100, 1'b0);
    for (int i = 0; i < 10; i++) enq_simple(64'(i), 1'b1);
    step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b0, 1'b1);

    // Flush with a concurrent command: the command is discarded.
    enq_simple(64'd21, 1'b0);
    enq_simple(64'd22, 1'b0);
    step(1'b1, 64'd23, 7'h01, 7'h02, 5'd4, 1'b0, 1'b1);
    step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b1, 1'b0);

    // Empty queue, command and consumer both ready.
    step(1'b1, 64'hAA, 7'h11, 7'h22, 5'd7, 1'b1, 1'b0);
    step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b1, 1'b0);
    // Flush suppresses forwarding on an empty queue.
    step(1'b1, 64'hBB, 7'h11, 7'h22, 5'd7, 1'b1, 1'b1);
    step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b1, 1'b0);

    // Randomized traffic, data inputs randomized even when not valid.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom}, 7'($urandom), 7'($urandom),
           5'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 39) == 0));
    end

    // Asynchronous reset mid-stream with three entries held.
    step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) enq_simple(64'(40 + i), 1'b0);
    cmd_val_i = 1'b0; deq_rdy_i = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_idle("async_rst", 1'b0);
    mq.delete();
    #1 reset = 1'b1;
    @(posedge clk); #1;
    enq_simple(64'h77, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b0, 64'h0, 7'h0, 7'h0, 5'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
